// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals shared by the arbiter and its environment.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [2*N_REQ-1:0] req_A;
    logic [2*N_REQ-1:0] req_B;
    logic [3*N_REQ-1:0] req_sel;
    logic [N_REQ-1:0]   req_ready;
    logic [1:0]         alu_A;
    logic [1:0]         alu_B;
    logic [2:0]         alu_select;
    logic [3:0]         alu_result;
    logic [N_REQ-1:0]   rsp_valid;
    logic [3:0]         rsp_data;
    logic               rsp_err;
    logic [N_REQ-1:0]   rsp_ready;
    logic               busy;

    modport slave (
        input  req_valid, req_A, req_B, req_sel, alu_result, rsp_ready,
        output req_ready, alu_A, alu_B, alu_select, rsp_valid, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req_A, req_B, req_sel, alu_result, rsp_ready,
        input  req_ready, alu_A, alu_B, alu_select, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one combinational 2-bit ALU among N_REQ requesters.
// One op in flight at a time: IDLE (grant) -> ISSUE (ALU settles) -> RESP (hand back).
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [1:0]         r_aluA;
    logic [1:0]         r_aluB;
    logic [2:0]         r_aluSel;
    logic [3:0]         r_rspData;
    logic               r_rspErr;
    logic [N_REQ-1:0]   r_rspValid;
    logic               r_busy;

    logic               w_grantValid;
    logic [PTR_W-1:0]   w_grantIdx;
    int                 w_idx;
    int                 w_grantInt;
    logic [1:0]         w_grantA;
    logic [1:0]         w_grantB;
    logic [2:0]         w_grantSel;
    logic               w_legal;
    logic [PTR_W-1:0]   w_nextPtr;
    logic [N_REQ-1:0]   w_reqReady;

    function automatic logic [N_REQ-1:0] oneHot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Descending scan so the requester closest to r_ptr (wrapping) is the one left standing.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_idx        = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (bus.req_valid[w_idx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_grantInt = int'(w_grantIdx);
        w_grantA   = bus.req_A[2*w_grantInt +: 2];
        w_grantB   = bus.req_B[2*w_grantInt +: 2];
        w_grantSel = bus.req_sel[3*w_grantInt +: 3];
        w_legal    = (w_grantSel <= 3'd5);
        w_nextPtr  = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + 1'b1;
    end

    // Gated by rst_n so no accept strobe is shown on an edge that reset will override.
    always_comb begin
        w_reqReady = '0;
        if (rst_n && (r_state == IDLE) && w_grantValid) begin
            w_reqReady[w_grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_aluA     <= '0;
            r_aluB     <= '0;
            r_aluSel   <= '0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
            r_rspValid <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_owner <= w_grantIdx;
                        r_busy  <= 1'b1;
                        if (w_legal) begin
                            r_aluA   <= w_grantA;
                            r_aluB   <= w_grantB;
                            r_aluSel <= w_grantSel;
                            r_state  <= ISSUE;
                        end else begin
                            r_rspData  <= '0;
                            r_rspErr   <= 1'b1;
                            r_rspValid <= oneHot(w_grantIdx);
                            r_state    <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    r_rspData  <= bus.alu_result;
                    r_rspErr   <= 1'b0;
                    r_rspValid <= oneHot(r_owner);
                    r_state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[r_owner]) begin
                        r_rspValid <= '0;
                        r_busy     <= 1'b0;
                        r_ptr      <= w_nextPtr;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_rspValid <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_reqReady;
    assign bus.alu_A      = r_aluA;
    assign bus.alu_B      = r_aluB;
    assign bus.alu_select = r_aluSel;
    assign bus.rsp_valid  = r_rspValid;
    assign bus.rsp_data   = r_rspData;
    assign bus.rsp_err    = r_rspErr;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU model closes the loop and
// hand-computed vectors cover grant order, latency, illegal ops, backpressure and reset.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    logic [3:0] aluResult;
    logic [3:0] expGrant;
    int checkCount;
    int errorCount;

    alu_arbiter_if #(.N_REQ(4)) bus ();

    alu_arbiter #(.N_REQ(4), .PTR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: results are zero-extended to 4 bits, SUB wraps modulo 16.
    always_comb begin
        case (bus.alu_select)
            3'd0:    aluResult = {2'b00, bus.alu_A & bus.alu_B};
            3'd1:    aluResult = {2'b00, bus.alu_A | bus.alu_B};
            3'd2:    aluResult = {2'b00, bus.alu_A ^ bus.alu_B};
            3'd3:    aluResult = {2'b00, bus.alu_A} + {2'b00, bus.alu_B};
            3'd4:    aluResult = {2'b00, bus.alu_A} - {2'b00, bus.alu_B};
            3'd5:    aluResult = {2'b00, bus.alu_A} * {2'b00, bus.alu_B};
            default: aluResult = 4'd0;
        endcase
    end
    assign bus.alu_result = aluResult;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] a, input logic [7:0] b,
                                 input logic [11:0] sel, input logic [3:0] rspReady);
        bus.req_valid = valid;
        bus.req_A     = a;
        bus.req_B     = b;
        bus.req_sel   = sel;
        bus.rsp_ready = rspReady;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        applyStimulus(4'b0000, 8'h00, 8'h00, 12'h000, 4'b0000);
        repeat (3) @(negedge clk);
        #1;

        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_alu_A", 32'(bus.alu_A), 32'd0);
        checkOutput("reset_alu_B", 32'(bus.alu_B), 32'd0);
        checkOutput("reset_alu_select", 32'(bus.alu_select), 32'd0);
        checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);

        // Requester 0: MUL 3*3 = 9
        applyStimulus(4'b0001, 8'h03, 8'h03, 12'h005, 4'b0000);
        checkOutput("mul_ready_in_reset", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("mul_req_ready", 32'(bus.req_ready), 32'b0001);
        nextCycle();
        applyStimulus(4'b0000, 8'h00, 8'h00, 12'h000, 4'b0000);
        checkOutput("mul_issue_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("mul_issue_busy", 32'(bus.busy), 32'd1);
        checkOutput("mul_issue_alu_A", 32'(bus.alu_A), 32'd3);
        checkOutput("mul_issue_alu_B", 32'(bus.alu_B), 32'd3);
        checkOutput("mul_issue_alu_select", 32'(bus.alu_select), 32'd5);
        checkOutput("mul_issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        nextCycle();
        checkOutput("mul_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        checkOutput("mul_rsp_data", 32'(bus.rsp_data), 32'd9);
        checkOutput("mul_rsp_err", 32'(bus.rsp_err), 32'd0);
        applyStimulus(4'b0000, 8'h00, 8'h00, 12'h000, 4'b1111);
        nextCycle();
        checkOutput("mul_done_busy", 32'(bus.busy), 32'd0);
        checkOutput("mul_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        // Round robin from ptr=0: all requesters ADD 3+2 = 5
        rst_n = 1'b0;
        nextCycle();
        applyStimulus(4'b1111, 8'hFF, 8'hAA, 12'h6DB, 4'b1111);
        rst_n = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            expGrant = 4'b0001 << (n % 4);
            checkOutput("rr_req_ready", 32'(bus.req_ready), 32'(expGrant));
            nextCycle();
            checkOutput("rr_issue_ready", 32'(bus.req_ready), 32'd0);
            nextCycle();
            checkOutput("rr_rsp_valid", 32'(bus.rsp_valid), 32'(expGrant));
            checkOutput("rr_rsp_data", 32'(bus.rsp_data), 32'd5);
            nextCycle();
        end
        applyStimulus(4'b0000, 8'h00, 8'h00, 12'h000, 4'b0000);

        // Requester 2 illegal opcode 110
        applyStimulus(4'b0100, 8'h00, 8'h00, 12'h180, 4'b0000);
        checkOutput("ill_req_ready", 32'(bus.req_ready), 32'b0100);
        nextCycle();
        applyStimulus(4'b0000, 8'h00, 8'h00, 12'h000, 4'b0000);
        checkOutput("ill_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        checkOutput("ill_rsp_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("ill_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("ill_alu_select", 32'(bus.alu_select), 32'd3);
        checkOutput("ill_busy", 32'(bus.busy), 32'd1);
        applyStimulus(4'b0000, 8'h00, 8'h00, 12'h000, 4'b0100);
        nextCycle();
        checkOutput("ill_done_busy", 32'(bus.busy), 32'd0);

        // Requester 1 AND 3&1 with response backpressure (ptr=3 wraps to 1)
        applyStimulus(4'b0010, 8'h0C, 8'h04, 12'h000, 4'b0000);
        checkOutput("bp_req_ready", 32'(bus.req_ready), 32'b0010);
        nextCycle();
        applyStimulus(4'b1001, 8'h80, 8'h40, 12'h800, 4'b0000);
        checkOutput("bp_issue_alu_A", 32'(bus.alu_A), 32'd3);
        checkOutput("bp_issue_alu_B", 32'(bus.alu_B), 32'd1);
        checkOutput("bp_issue_alu_select", 32'(bus.alu_select), 32'd0);
        nextCycle();
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
            checkOutput("bp_rsp_data", 32'(bus.rsp_data), 32'd1);
            checkOutput("bp_req_ready", 32'(bus.req_ready), 32'd0);
            if (c == 2) begin
                applyStimulus(4'b1001, 8'h80, 8'h40, 12'h800, 4'b1101);
            end
            nextCycle();
        end
        checkOutput("bp_nonowner_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
        checkOutput("bp_nonowner_busy", 32'(bus.busy), 32'd1);
        applyStimulus(4'b1001, 8'h80, 8'h40, 12'h800, 4'b0010);
        checkOutput("bp_take_req_ready", 32'(bus.req_ready), 32'd0);
        nextCycle();
        applyStimulus(4'b1001, 8'h80, 8'h40, 12'h800, 4'b0000);
        checkOutput("bp_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("bp_after_grant", 32'(bus.req_ready), 32'b1000);

        // Requester 3 SUB 2-1, reset lands while in ISSUE
        nextCycle();
        checkOutput("sub_issue_alu_select", 32'(bus.alu_select), 32'd4);
        checkOutput("sub_issue_alu_A", 32'(bus.alu_A), 32'd2);
        checkOutput("sub_issue_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        nextCycle();
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("midrst_alu_A", 32'(bus.alu_A), 32'd0);
        checkOutput("midrst_alu_B", 32'(bus.alu_B), 32'd0);
        checkOutput("midrst_alu_select", 32'(bus.alu_select), 32'd0);
        checkOutput("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("postrst_grant", 32'(bus.req_ready), 32'b0001);
        applyStimulus(4'b0000, 8'h00, 8'h00, 12'h000, 4'b1111);
        nextCycle();
        checkOutput("postrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
